// File: rtl/ex_issue_stage_pkg.sv
// Shared definitions for the ID/EX issue stage: datapath width, ALU op
// encodings, ALU control codes, the held-instruction payload and a hazard-match helper.
package ex_issue_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 4;

  // Coarse operation class produced by the main decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_ITYPE  = 2'b11
  } alu_op_e;

  // Operation codes consumed by the ALU
  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  // Instruction held in the ID/EX register
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              src_a_pc;
    logic              src_b_imm;
    logic              regwrite;
    logic              is_load;
    logic [CTRL_W-1:0] alu_ctrl;
  } issue_entry_t;

  // A source register depends on a writer: writer enabled, same index, never x0
  function automatic logic reg_hit(input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rd,
                                   input logic              we);
    return we && (rs != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode-to-issue and issue-to-ALU handshake bundle.
// slave: the issue stage; master: the surrounding decode/ALU side.
interface ex_issue_stage_if;
  import ex_issue_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [XLEN-1:0]     in_imm;
  logic [XLEN-1:0]     in_rs1_data;
  logic [XLEN-1:0]     in_rs2_data;
  logic [REG_AW-1:0]   in_rs1;
  logic [REG_AW-1:0]   in_rs2;
  logic [REG_AW-1:0]   in_rd;
  logic [2:0]          in_funct3;
  logic                in_funct7_5;
  logic [1:0]          in_alu_op;
  logic                in_src_a_pc;
  logic                in_src_b_imm;
  logic                in_regwrite;
  logic                in_is_load;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     inA;
  logic [XLEN-1:0]     inB;
  logic [CTRL_W-1:0]   alu_ctrl;
  logic [XLEN-1:0]     store_data;
  logic [REG_AW-1:0]   out_rd;
  logic [2:0]          out_funct3;
  logic                out_regwrite;
  logic                out_is_load;

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data, in_rs1, in_rs2, in_rd,
           in_funct3, in_funct7_5, in_alu_op, in_src_a_pc, in_src_b_imm,
           in_regwrite, in_is_load, out_ready,
    output in_ready, out_valid, inA, inB, alu_ctrl, store_data, out_rd, out_funct3,
           out_regwrite, out_is_load
  );

  modport master (
    output in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data, in_rs1, in_rs2, in_rd,
           in_funct3, in_funct7_5, in_alu_op, in_src_a_pc, in_src_b_imm,
           in_regwrite, in_is_load, out_ready,
    input  in_ready, out_valid, inA, inB, alu_ctrl, store_data, out_rd, out_funct3,
           out_regwrite, out_is_load
  );

endinterface

// File: rtl/ex_issue_stage_alu_ctrl_decode.sv
// ALU control decoder: alu_op/funct3/instr[30] -> 4-bit ALU operation.
// Purely combinational so the single-cycle datapath can reuse it.
module alu_ctrl_decode
  import ex_issue_stage_pkg::*;
(
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CTRL_W-1:0] alu_ctrl_c
);

  // SUB only exists for R-type; instr[30] selects SRA for both R and I shifts
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD:    alu_ctrl_c = ALU_ADD;
      ALU_OP_BRANCH: alu_ctrl_c = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl_c = (alu_op == ALU_OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_c = ALU_SLL;
          3'b010:  alu_ctrl_c = ALU_SLT;
          3'b011:  alu_ctrl_c = ALU_SLTU;
          3'b100:  alu_ctrl_c = ALU_XOR;
          3'b101:  alu_ctrl_c = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_c = ALU_OR;
          default: alu_ctrl_c = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: one-entry valid/ready register between decode and the ALU.
// Decodes ALU control at capture, selects operands, and stalls decode on hazards.
// Optional feature macro FORWARDING_EN: EX/MEM and MEM/WB bypass with load-use stall.
// Without it, operands come from captured register data and decode stalls on any
// pending writer of a source register.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ex_issue_stage_if.slave   bus,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic [XLEN-1:0]   memwb_result
);

  issue_entry_t      entry_q;
  issue_entry_t      entry_d;
  logic              valid_q;
  logic              stall_c;
  logic              accept_c;
  logic [CTRL_W-1:0] dec_alu_ctrl_c;
  logic [XLEN-1:0]   fwd_rs1_c;
  logic [XLEN-1:0]   fwd_rs2_c;

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op     (bus.in_alu_op),
    .funct3     (bus.in_funct3),
    .funct7_5   (bus.in_funct7_5),
    .alu_ctrl_c (dec_alu_ctrl_c)
  );

`ifdef FORWARDING_EN
  // Only a load still in this stage cannot be bypassed in time
  assign stall_c = reg_hit(bus.in_rs1, entry_q.rd, valid_q && entry_q.is_load) ||
                   reg_hit(bus.in_rs2, entry_q.rd, valid_q && entry_q.is_load);

  // Bypass mux per source; the younger EX/MEM result takes priority
  always_comb begin
    fwd_rs1_c = entry_q.rs1_data;
    fwd_rs2_c = entry_q.rs2_data;
    if (reg_hit(entry_q.rs1, exmem_rd, exmem_regwrite))      fwd_rs1_c = exmem_result;
    else if (reg_hit(entry_q.rs1, memwb_rd, memwb_regwrite)) fwd_rs1_c = memwb_result;
    if (reg_hit(entry_q.rs2, exmem_rd, exmem_regwrite))      fwd_rs2_c = exmem_result;
    else if (reg_hit(entry_q.rs2, memwb_rd, memwb_regwrite)) fwd_rs2_c = memwb_result;
  end
`else
  logic unused_fwd;

  // Any in-flight writer of an incoming source blocks decode until it retires
  always_comb begin
    stall_c = 1'b0;
    if (reg_hit(bus.in_rs1, entry_q.rd, valid_q && entry_q.regwrite) ||
        reg_hit(bus.in_rs2, entry_q.rd, valid_q && entry_q.regwrite) ||
        reg_hit(bus.in_rs1, exmem_rd, exmem_regwrite) ||
        reg_hit(bus.in_rs2, exmem_rd, exmem_regwrite) ||
        reg_hit(bus.in_rs1, memwb_rd, memwb_regwrite) ||
        reg_hit(bus.in_rs2, memwb_rd, memwb_regwrite))
      stall_c = 1'b1;
  end

  assign fwd_rs1_c  = entry_q.rs1_data;
  assign fwd_rs2_c  = entry_q.rs2_data;
  assign unused_fwd = ^{entry_q.rs1, entry_q.rs2, exmem_result, memwb_result};
`endif

  assign bus.in_ready = (!valid_q || bus.out_ready) && !stall_c && !flush;
  assign accept_c     = bus.in_valid && bus.in_ready;

  // Payload presented by decode, with ALU control decoded on the way in
  always_comb begin
    entry_d           = '0;
    entry_d.pc        = bus.in_pc;
    entry_d.imm       = bus.in_imm;
    entry_d.rs1_data  = bus.in_rs1_data;
    entry_d.rs2_data  = bus.in_rs2_data;
    entry_d.rs1       = bus.in_rs1;
    entry_d.rs2       = bus.in_rs2;
    entry_d.rd        = bus.in_rd;
    entry_d.funct3    = bus.in_funct3;
    entry_d.src_a_pc  = bus.in_src_a_pc;
    entry_d.src_b_imm = bus.in_src_b_imm;
    entry_d.regwrite  = bus.in_regwrite;
    entry_d.is_load   = bus.in_is_load;
    entry_d.alu_ctrl  = dec_alu_ctrl_c;
  end

  // Pipeline register: flush beats accept; fields only change on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q <= 1'b1;
      entry_q <= entry_d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.alu_ctrl     = entry_q.alu_ctrl;
  assign bus.out_rd       = entry_q.rd;
  assign bus.out_funct3   = entry_q.funct3;
  assign bus.out_regwrite = entry_q.regwrite;
  assign bus.out_is_load  = entry_q.is_load;
  assign bus.inA          = entry_q.src_a_pc  ? entry_q.pc  : fwd_rs1_c;
  assign bus.inB          = entry_q.src_b_imm ? entry_q.imm : fwd_rs2_c;
  assign bus.store_data   = fwd_rs2_c;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage. Expected outputs are queued on accept and
// checked by an independent monitor whenever the stage fires an instruction.
module tb_ex_issue_stage;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        sa;
    logic        sbi;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rw;
    logic        ld;
  } in_t;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw;
    logic        ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  exmem_rd = '0;
  logic        exmem_regwrite = 1'b0;
  logic [31:0] exmem_result = '0;
  logic [4:0]  memwb_rd = '0;
  logic        memwb_regwrite = 1'b0;
  logic [31:0] memwb_result = '0;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  ex_issue_stage_if bus();

  ex_issue_stage dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .flush          (flush),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(logic [1:0] op, logic [2:0] f3, logic f7, logic sa, logic sbi,
                             logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                             logic [31:0] r1d, logic [31:0] r2d, logic [31:0] imm,
                             logic [31:0] pc, logic rw, logic ld);
    in_t i;
    i.op = op; i.f3 = f3; i.f7 = f7; i.sa = sa; i.sbi = sbi;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.r1d = r1d; i.r2d = r2d;
    i.imm = imm; i.pc = pc; i.rw = rw; i.ld = ld;
    return i;
  endfunction

  function automatic exp_t ex(logic [3:0] alu, logic [31:0] a, logic [31:0] b, logic [31:0] sd,
                              logic [4:0] rd, logic [2:0] f3, logic rw, logic ld);
    exp_t e;
    e.alu = alu; e.a = a; e.b = b; e.sd = sd; e.rd = rd; e.f3 = f3; e.rw = rw; e.ld = ld;
    return e;
  endfunction

  task automatic apply(input in_t i);
    bus.in_alu_op    = i.op;
    bus.in_funct3    = i.f3;
    bus.in_funct7_5  = i.f7;
    bus.in_src_a_pc  = i.sa;
    bus.in_src_b_imm = i.sbi;
    bus.in_rs1       = i.rs1;
    bus.in_rs2       = i.rs2;
    bus.in_rd        = i.rd;
    bus.in_rs1_data  = i.r1d;
    bus.in_rs2_data  = i.r2d;
    bus.in_imm       = i.imm;
    bus.in_pc        = i.pc;
    bus.in_regwrite  = i.rw;
    bus.in_is_load   = i.ld;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, queue its expected output
  task automatic send(input in_t i, input exp_t e);
    int waited;
    apply(i);
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compare each fired instruction against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rd=%0d fired with empty queue at %0t", bus.out_rd, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(e.alu));
        chk("inA", bus.inA, e.a);
        chk("inB", bus.inB, e.b);
        chk("store_data", bus.store_data, e.sd);
        chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
        chk("out_funct3", 32'(bus.out_funct3), 32'(e.f3));
        chk("out_regwrite", 32'(bus.out_regwrite), 32'(e.rw));
        chk("out_is_load", 32'(bus.out_is_load), 32'(e.ld));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  junk;
    exp_t ek;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    apply(mk(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("rst_inA", bus.inA, 32'd0);
    chk("rst_inB", bus.inB, 32'd0);
    chk("rst_store_data", bus.store_data, 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_funct3", 32'(bus.out_funct3), 32'd0);
    chk("rst_out_regwrite", 32'(bus.out_regwrite), 32'd0);
    chk("rst_out_is_load", 32'(bus.out_is_load), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // ALU control decode and operand select, back to back
    send(mk(2'b10, 3'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'd10, 32'd3, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0001, 32'd10, 32'd3, 32'd3, 5'd10, 3'd0, 1'b1, 1'b0));
    send(mk(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11, 32'd10, 32'd3, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0000, 32'd10, 32'd3, 32'd3, 5'd11, 3'd0, 1'b1, 1'b0));
    send(mk(2'b11, 3'd5, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd12, 32'h8000_0000, 32'h77, 32'd4, 32'h0, 1'b1, 1'b0),
         ex(4'b0111, 32'h8000_0000, 32'd4, 32'h77, 5'd12, 3'd5, 1'b1, 1'b0));
    send(mk(2'b11, 3'd0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd13, 32'd20, 32'd9, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0),
         ex(4'b0000, 32'd20, 32'hFFFF_FFFF, 32'd9, 5'd13, 3'd0, 1'b1, 1'b0));
    send(mk(2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd7, 32'd8, 32'h40, 32'h0, 1'b0, 1'b0),
         ex(4'b0001, 32'd7, 32'd8, 32'd8, 5'd0, 3'd1, 1'b0, 1'b0));
    send(mk(2'b00, 3'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd14, 32'd7, 32'd8, 32'd8, 32'h100, 1'b1, 1'b0),
         ex(4'b0000, 32'h100, 32'd8, 32'd8, 5'd14, 3'd0, 1'b1, 1'b0));
    send(mk(2'b10, 3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd15, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0101, 32'd1, 32'd2, 32'd2, 5'd15, 3'd1, 1'b1, 1'b0));
    send(mk(2'b10, 3'd2, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd16, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b1000, 32'd1, 32'd2, 32'd2, 5'd16, 3'd2, 1'b1, 1'b0));
    send(mk(2'b11, 3'd3, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd17, 32'd1, 32'd2, 32'd5, 32'h0, 1'b1, 1'b0),
         ex(4'b1001, 32'd1, 32'd5, 32'd2, 5'd17, 3'd3, 1'b1, 1'b0));
    send(mk(2'b10, 3'd4, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd18, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0100, 32'd1, 32'd2, 32'd2, 5'd18, 3'd4, 1'b1, 1'b0));
    send(mk(2'b10, 3'd5, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd19, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0110, 32'd1, 32'd2, 32'd2, 5'd19, 3'd5, 1'b1, 1'b0));
    send(mk(2'b10, 3'd5, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd20, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0111, 32'd1, 32'd2, 32'd2, 5'd20, 3'd5, 1'b1, 1'b0));
    send(mk(2'b10, 3'd6, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd21, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0011, 32'd1, 32'd2, 32'd2, 5'd21, 3'd6, 1'b1, 1'b0));
    send(mk(2'b10, 3'd7, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd22, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0010, 32'd1, 32'd2, 32'd2, 5'd22, 3'd7, 1'b1, 1'b0));
    idle(2);

    // Back-pressure: held fields stay put, decode blocked
    bus.out_ready = 1'b0;
    send(mk(2'b10, 3'd4, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd23, 32'hA5, 32'h5A, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0100, 32'hA5, 32'h5A, 32'h5A, 5'd23, 3'd4, 1'b1, 1'b0));
    junk = mk(2'b10, 3'd7, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd24, 32'h1, 32'h2, 32'd0, 32'h0, 1'b1, 1'b0);
    apply(junk);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_alu_ctrl", 32'(bus.alu_ctrl), 32'b0100);
      chk("bp_inA", bus.inA, 32'hA5);
      chk("bp_out_rd", 32'(bus.out_rd), 32'd23);
    end

    // Flush with a valid incoming instruction: held one squashed, new one not taken
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("flush_not_captured", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Load-use: one stalled cycle and exactly one bubble
    send(mk(2'b00, 3'd2, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd7, 32'h40, 32'h0, 32'd4, 32'h0, 1'b1, 1'b1),
         ex(4'b0000, 32'h40, 32'd4, 32'h0, 5'd7, 3'd2, 1'b1, 1'b1));
    apply(mk(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd7, 5'd8, 32'd5, 32'd6, 32'd0, 32'h0, 1'b1, 1'b0));
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lu_stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("lu_load_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("lu_bubble", 32'(bus.out_valid), 32'd0);
    chk("lu_release_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back(ex(4'b0000, 32'd5, 32'd6, 32'd6, 5'd8, 3'd0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lu_dep_valid", 32'(bus.out_valid), 32'd1);
    idle(2);

`ifdef FORWARDING_EN
    // Bypass priority while an instruction is held
    bus.out_ready = 1'b0;
    send(mk(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd9, 32'h99, 32'h66, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0000, 32'h99, 32'h66, 32'h66, 5'd9, 3'd0, 1'b1, 1'b0));
    exmem_rd = 5'd5; exmem_regwrite = 1'b1; exmem_result = 32'h11;
    memwb_rd = 5'd5; memwb_regwrite = 1'b1; memwb_result = 32'h22;
    #1;
    chk("fwd_exmem_wins", bus.inA, 32'h11);
    exmem_regwrite = 1'b0;
    #1;
    chk("fwd_memwb", bus.inA, 32'h22);
    memwb_rd = 5'd6;
    #1;
    chk("fwd_rs2_inB", bus.inB, 32'h22);
    chk("fwd_rs2_store", bus.store_data, 32'h22);
    chk("fwd_rs1_none", bus.inA, 32'h99);
    memwb_regwrite = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    bus.out_ready = 1'b0;
    send(mk(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd9, 32'h55, 32'h66, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0000, 32'h55, 32'h66, 32'h66, 5'd9, 3'd0, 1'b1, 1'b0));
    exmem_rd = 5'd0; exmem_regwrite = 1'b1; exmem_result = 32'hDEAD;
    memwb_rd = 5'd0; memwb_regwrite = 1'b1; memwb_result = 32'hBEEF;
    #1;
    chk("fwd_x0_never", bus.inA, 32'h55);
    exmem_regwrite = 1'b0;
    memwb_regwrite = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
`else
    // Without bypass: decode waits for EX/MEM then MEM/WB writers to retire
    exmem_rd = 5'd5; exmem_regwrite = 1'b1; exmem_result = 32'h11;
    apply(mk(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd2, 5'd9, 32'h99, 32'h66, 32'd0, 32'h0, 1'b1, 1'b0));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("raw_exmem_stall", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    exmem_regwrite = 1'b0;
    memwb_rd = 5'd5; memwb_regwrite = 1'b1;
    @(negedge clk);
    chk("raw_memwb_stall", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    memwb_regwrite = 1'b0;
    @(negedge clk);
    chk("raw_cleared", 32'(bus.in_ready), 32'd1);
    sb.push_back(ex(4'b0000, 32'h99, 32'h66, 32'h66, 5'd9, 3'd0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    idle(2);
    // Operands ignore later-stage results
    bus.out_ready = 1'b0;
    send(mk(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd2, 5'd9, 32'h33, 32'h44, 32'd0, 32'h0, 1'b1, 1'b0),
         ex(4'b0000, 32'h33, 32'h44, 32'h44, 5'd9, 3'd0, 1'b1, 1'b0));
    exmem_rd = 5'd4; exmem_regwrite = 1'b1; exmem_result = 32'h11;
    #1;
    chk("no_bypass_inA", bus.inA, 32'h33);
    exmem_regwrite = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
`endif

    // Reset while an instruction is held drops it
    bus.out_ready = 1'b0;
    ek = ex(4'b0010, 32'h1, 32'h2, 32'h2, 5'd12, 3'd7, 1'b1, 1'b0);
    send(mk(2'b10, 3'd7, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'd0, 32'h0, 1'b1, 1'b0), ek);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("midrst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
